// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared types and elaboration helpers for the im2col convolution
//            engine (state encoding, output-grid sizing, accumulator check).
// Revision : 1.0 - initial parametrised release
// ============================================================================
package conv_pkg;

    // Engine sequencing states, explicitly encoded in 3 bits.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_MUL   = 3'd2,
        S_SUM   = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    // Number of window rows that fit in the strip; leftover rows are ignored.
    function automatic int out_rows(input int img_h, input int k, input int stride);
        return (img_h - k) / stride + 1;
    endfunction

    // Number of window columns that fit in the strip; leftover columns are ignored.
    function automatic int out_cols(input int img_w, input int k, input int stride);
        return (img_w - k) / stride + 1;
    endfunction

    // True when the accumulator can hold a full-precision K*K dot product.
    function automatic bit acc_w_legal(input int acc_w, input int dw, input int kw, input int k);
        return acc_w >= dw + kw + $clog2(k * k);
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_window_mac.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_mac
// Brief    : K*K-lane signed multiply register followed by a sign-extended
//            adder tree and optional ReLU clamp; 2-cycle latency (MUL, SUM).
// Revision : 1.0 - initial parametrised release
// ============================================================================
module conv_window_mac #(
    parameter int K     = 3,
    parameter int DW    = 9,
    parameter int KW    = 9,
    parameter int ACC_W = 23
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_mul_en,
    input  logic                    i_sum_en,
    input  logic                    i_relu_en,
    input  logic signed [DW-1:0]    i_pix  [K*K],
    input  logic signed [KW-1:0]    i_coef [K*K],
    output logic signed [ACC_W-1:0] o_acc
);

    localparam int KK = K * K;
    localparam int PW = DW + KW;

    logic signed [PW-1:0]    prod_q [KK];
    logic signed [PW-1:0]    prod_d [KK];
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_relu;

    // Products are captured only in the MUL cycle and held otherwise.
    always_comb begin
        prod_d = prod_q;
        for (int n = 0; n < KK; n++) begin
            if (i_mul_en) begin
                prod_d[n] = PW'(i_pix[n]) * PW'(i_coef[n]);
            end
        end
    end

    // Sign-extend every product to the accumulator width and add, then clamp.
    always_comb begin
        w_sum = '0;
        for (int n = 0; n < KK; n++) begin
            w_sum = w_sum + ACC_W'(prod_q[n]);
        end
        w_relu = (i_relu_en && w_sum[ACC_W-1]) ? '0 : w_sum;
        acc_d  = i_sum_en ? w_relu : acc_q;
    end

    // Product and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < KK; n++) begin
                prod_q[n] <= '0;
            end
            acc_q <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

    assign o_acc = acc_q;

endmodule
`default_nettype wire

// File: rtl/im2col_conv_engine.sv
`default_nettype none
// ============================================================================
// Module   : im2col_conv_engine
// Brief    : Slides a KxK signed kernel over an IMG_H x IMG_W strip, gathering
//            each window from a 1-cycle-latency memory and streaming the
//            (optionally ReLU-clamped) dot products with row/column tags.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module im2col_conv_engine
    import conv_pkg::*;
#(
    parameter int K      = 3,
    parameter int IMG_W  = 224,
    parameter int IMG_H  = 30,
    parameter int STRIDE = 1,
    parameter int DW     = 9,
    parameter int KW     = 9,
    parameter int AW     = 16,
    parameter int ACC_W  = 23
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      relu_en,
    input  logic                      k_wr_en,
    input  logic [$clog2(K*K)-1:0]    k_wr_idx,
    input  logic signed [KW-1:0]      k_wr_data,
    output logic                      fmap_en,
    output logic [AW-1:0]             fmap_addr,
    input  logic signed [DW-1:0]      fmap_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [ACC_W-1:0]   out_data,
    output logic [7:0]                out_row,
    output logic [7:0]                out_col,
    output logic                      busy,
    output logic                      done
);

    localparam int KK       = K * K;
    localparam int IXW      = $clog2(KK);
    localparam int CW       = $clog2(KK + 1);
    localparam int IW       = $clog2(K);
    localparam int OUT_ROWS = out_rows(IMG_H, K, STRIDE);
    localparam int OUT_COLS = out_cols(IMG_W, K, STRIDE);

    localparam logic [CW-1:0] KK_C     = CW'(KK);
    localparam logic [IW-1:0] K_LAST   = IW'(K - 1);
    localparam logic [7:0]    LAST_ROW = 8'(OUT_ROWS - 1);
    localparam logic [7:0]    LAST_COL = 8'(OUT_COLS - 1);

    if (!acc_w_legal(ACC_W, DW, KW, K)) begin : g_bad_acc_w
        $error("im2col_conv_engine: ACC_W too narrow for full-precision sum");
    end
    if ((64'd1 << AW) < 64'(IMG_W * IMG_H)) begin : g_bad_aw
        $error("im2col_conv_engine: AW cannot address the whole strip");
    end

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        i_q, i_d, j_q, j_d;
    logic [7:0]           r_q, r_d, c_q, c_d;
    logic [7:0]           out_row_q, out_row_d, out_col_q, out_col_d;
    logic                 relu_q, relu_d;
    logic signed [KW-1:0] kern_q [KK];
    logic signed [KW-1:0] kern_d [KK];
    logic signed [DW-1:0] win_q  [KK];
    logic signed [DW-1:0] win_d  [KK];
    logic [31:0]          w_pix_row, w_pix_col, w_addr;

    // Pixel coordinate of the element being issued within the current window.
    always_comb begin
        w_pix_row = 32'(r_q) * 32'(STRIDE) + 32'(i_q);
        w_pix_col = 32'(c_q) * 32'(STRIDE) + 32'(j_q);
        w_addr    = w_pix_row * 32'(IMG_W) + w_pix_col;
    end

    // Sequencer: window walk, fetch counter and output tag capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        i_d       = i_q;
        j_d       = j_q;
        r_d       = r_q;
        c_d       = c_q;
        relu_d    = relu_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    r_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    relu_d  = relu_en;
                end
            end
            S_FETCH: begin
                // The extra cycle at cnt==KK only collects the last read's data.
                if (cnt_q == KK_C) begin
                    state_d = S_MUL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (j_q == K_LAST) begin
                        j_d = '0;
                        i_d = (i_q == K_LAST) ? '0 : i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            S_MUL: state_d = S_SUM;
            S_SUM: begin
                state_d   = S_EMIT;
                out_row_d = r_q;
                out_col_d = c_q;
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (c_q == LAST_COL) begin
                        c_d = '0;
                        if (r_q == LAST_ROW) begin
                            state_d = S_DONE;
                        end else begin
                            r_d     = r_q + 1'b1;
                            state_d = S_FETCH;
                        end
                    end else begin
                        c_d     = c_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Kernel writes only land while idle; window slots fill one cycle behind issue.
    always_comb begin
        kern_d = kern_q;
        win_d  = win_q;
        for (int n = 0; n < KK; n++) begin
            if (state_q == S_IDLE && k_wr_en && k_wr_idx == IXW'(n)) begin
                kern_d[n] = k_wr_data;
            end
            if (state_q == S_FETCH && cnt_q == CW'(n + 1)) begin
                win_d[n] = fmap_rdata;
            end
        end
    end

    // State, counters, kernel and window storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            relu_q    <= 1'b0;
            out_row_q <= '0;
            out_col_q <= '0;
            for (int n = 0; n < KK; n++) begin
                kern_q[n] <= '0;
                win_q[n]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            i_q       <= i_d;
            j_q       <= j_d;
            r_q       <= r_d;
            c_q       <= c_d;
            relu_q    <= relu_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
            kern_q    <= kern_d;
            win_q     <= win_d;
        end
    end

    conv_window_mac #(
        .K     (K),
        .DW    (DW),
        .KW    (KW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .i_mul_en  (state_q == S_MUL),
        .i_sum_en  (state_q == S_SUM),
        .i_relu_en (relu_q),
        .i_pix     (win_q),
        .i_coef    (kern_q),
        .o_acc     (out_data)
    );

    assign fmap_en   = (state_q == S_FETCH) && (cnt_q != KK_C);
    assign fmap_addr = fmap_en ? AW'(w_addr) : '0;
    assign out_valid = (state_q == S_EMIT);
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire
